adder_sched: RTL
================

# adder_sched

Round-robin scheduler that time-shares one W-bit adder core among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle, computes the sum through the shared core, and holds the result in a one-deep output register tagged with the requester index. It sits between the operand producers and the single adder netlist so that only one adder instance is evaluated per cycle.

## Interface
- `NREQ`, default 4: number of requesters, range 2..16.
- `W`, default 8: operand and sum width.
- `IDW`, default `$clog2(NREQ)`: width of the requester index. Derived; do not override.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  bit i set: requester i presents an operand pair.
- `req_a`  in  NREQ*W  operand A; slice i is `[i*W +: W]`.
- `req_b`  in  NREQ*W  operand B; slice i is `[i*W +: W]`.
- `req_ready`  out  NREQ  one-hot or zero grant; combinational.
- `resp_valid`  out  1  output register holds a result.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  IDW  index of the requester whose result is held.
- `resp_sum`  out  W  `(a+b) mod 2^W`.
- `resp_cout`  out  1  carry out of the addition. Present only when `ADDER_SCHED_CARRY_EN` is defined.
- `ops_done`  out  16  count of completed response handshakes; wraps modulo 2^16.

## Operation
- **States:** EMPTY (no result held) and FULL (result held).
- **Transitions:**
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on drain without a grant.
  - FULL→FULL on drain with a simultaneous grant, or on no drain.
- **Drain:** `resp_valid && resp_ready`.
- **Grant allowed:** state is EMPTY, or state is FULL with a drain in the same cycle.
- **Grant selection:** among set `req_valid` bits, pick the first index found scanning upward from `ptr+1` modulo NREQ. Drive `req_ready` one-hot on that index.
- **Grant not allowed:** `req_ready` is all zero.
- **On a grant:**
  - `resp_sum` and `resp_id` load the granted requester's sum and index.
  - `ptr` loads the granted index.
- **Arithmetic:** the full sum is W+1 bits. The low W bits go to `resp_sum`; bit W is the carry out.
- **Requester rules:** a requester holds `req_valid` and its operands stable until it sees `req_ready`. The scheduler never drops a valid request; with all others active, the longest wait is NREQ−1 grants.
- **`ops_done`:** increments by 1 on each drain.
- **Reset** (`rst_n` low at a rising edge), including in the middle of operation:
  - state = EMPTY; `resp_valid` = 0.
  - `resp_sum` = 0, `resp_id` = 0, `resp_cout` = 0.
  - `ptr` = NREQ−1, so requester 0 has first priority.
  - `ops_done` = 0.
  - Any held result is discarded.
  - `req_ready` is all zero while `rst_n` is low.

## Timing
- Request handshake at edge N → `resp_valid` high after edge N with the sum. Latency is 1 cycle.
- Throughput: one result per cycle while `resp_ready` is held high. No bubble on simultaneous drain and accept.
- Backpressure: `resp_ready` low while FULL → `req_ready` all zero. `resp_*` stay stable until drained.
- `req_ready` depends combinationally on `req_valid`, `resp_ready` and the state.
- `resp_*` and `ops_done` are registered outputs.

## Configuration
- **`ADDER_SCHED_CARRY_EN` defined:**
  - `resp_cout` port exists.
  - It is loaded with bit W of the sum on a grant and cleared on reset.
- **`ADDER_SCHED_CARRY_EN` undefined:**
  - No `resp_cout` port.
  - The carry is discarded and the sum wraps modulo 2^W.
  - All other behaviour is identical.

## Structure
- **Package `adder_sched_pkg`:**
  - State enum `sched_state_e` {EMPTY, FULL}.
  - Default constants `NREQ_DEF = 4` and `W_DEF = 8`.
  - Function `rr_pick(valid, ptr)`, returning a one-hot grant.
- **Sub-module `add_core`:**
  - Purely combinational W-bit adder: inputs `a`, `b`; output a W+1-bit sum.
  - Instantiated exactly once; its inputs are muxed by the grant.

## Test plan
- **Reset state:** reset, then `req_valid`=0 → `resp_valid`=0, `ops_done`=0, `req_ready`=0.
- **Single request:** NREQ=4, W=8, requester 2 sends a=0x37, b=0x4C, `resp_ready`=1 → next cycle `resp_valid`=1, `resp_id`=2, `resp_sum`=0x83.
- **Wrap and carry:** a=0xFF, b=0x02 → `resp_sum`=0x01. With `ADDER_SCHED_CARRY_EN`, `resp_cout`=1.
- **Round-robin fairness:** all four requesters valid continuously, `resp_ready`=1 → grants in order 0,1,2,3,0; `ops_done` increments each cycle.
- **Backpressure:** `resp_ready`=0 for 3 cycles with requests pending → `req_ready`=0 and `resp_*` stable. Raising `resp_ready` → drain and new grant in the same cycle.
- **Reset mid-operation:** assert `rst_n`=0 while FULL with `resp_id`=1 → after the edge `resp_valid`=0 and `ops_done`=0. The next grant goes to requester 0 if it is valid.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types, default constants and the round-robin pick helper for adder_sched.
// The optional carry-out output is controlled by the ADDER_SCHED_CARRY_EN macro.
package adder_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_e;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int RR_MAX   = 16;

  // Returns a one-hot grant for the first valid index found scanning upward
  // from ptr+1, wrapping modulo n. Vectors are sized for the largest n.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] valid,
    input logic [3:0]        ptr,
    input int                n
  );
    logic [RR_MAX-1:0] grant;
    logic              found;
    int                idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/adder_sched_add_core.sv
// The single shared adder: purely combinational, carry kept as the top sum bit.
module add_core #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one adder among NREQ requesters with a one-deep result register.
// Defining ADDER_SCHED_CARRY_EN adds the resp_cout output.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_sum,
`ifdef ADDER_SCHED_CARRY_EN
  output logic              resp_cout,
`endif
  output logic [15:0]       ops_done
);

  sched_state_e     r_state;
  sched_state_e     w_state_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [W-1:0]     r_sum;
  logic [15:0]      r_ops;

  logic             w_drain;
  logic             w_grant_ok;
  logic             w_grant;
  logic [NREQ-1:0]  w_pick;
  logic [IDW-1:0]   w_gnt_id;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W:0]       w_sum;

  assign w_drain    = (r_state == FULL) && resp_ready;
  assign w_grant_ok = rst_n && ((r_state == EMPTY) || w_drain);
  assign w_pick     = NREQ'(rr_pick(RR_MAX'(req_valid), 4'(r_ptr), NREQ));
  assign req_ready  = w_grant_ok ? w_pick : '0;
  assign w_grant    = |req_ready;

  // req_ready is one-hot, so at most one slice passes through the mux.
  always_comb begin
    w_gnt_id = '0;
    w_a      = '0;
    w_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_gnt_id = IDW'(i);
        w_a      = req_a[i*W +: W];
        w_b      = req_b[i*W +: W];
      end
    end
  end

  add_core #(.W(W)) u_add_core (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_grant) begin
      w_state_next = FULL;
    end else if (w_drain) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_sum   <= '0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_ptr <= w_gnt_id;
        r_id  <= w_gnt_id;
        r_sum <= w_sum[W-1:0];
      end
      if (w_drain) begin
        r_ops <= r_ops + 16'd1;
      end
    end
  end

`ifdef ADDER_SCHED_CARRY_EN
  logic r_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cout <= 1'b0;
    end else if (w_grant) begin
      r_cout <= w_sum[W];
    end
  end

  assign resp_cout = r_cout;
`else
  logic w_carry_unused;
  assign w_carry_unused = w_sum[W];
`endif

  assign resp_valid = (r_state == FULL);
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
  assign ops_done   = r_ops;

endmodule
